// File: rtl/pause_fade_ctl.sv
// Pause merger and idle-fade video dimmer for arcade cores (clk_sys domain).
// Merges user/OSD/subsystem pause into one CPU gate, then fades RGB down in shift steps.
module pause_fade_ctl #(
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int NREQ        = 2,
  parameter int CLK_HZ      = 12000000,
  parameter int DIM_SEC     = 10,
  parameter int DIM_SHIFT   = 2,
  parameter int STEP_CYCLES = 1200000,
  localparam int CW         = RW + GW + BW,
  localparam int DLW        = (DIM_SHIFT >= 1) ? $clog2(DIM_SHIFT + 1) : 1
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            user_button,
  input  logic [NREQ-1:0] pause_req,
  input  logic            osd_status,
  input  logic [1:0]      options,
  input  logic [CW-1:0]   rgb_in,
  output logic            pause_cpu,
  output logic [CW-1:0]   rgb_out,
  output logic [DLW-1:0]  dim_level
);

  localparam int IDLE_TC = CLK_HZ * DIM_SEC;
  localparam int IW      = (IDLE_TC > 1) ? $clog2(IDLE_TC) : 1;
  localparam int SW      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [IW-1:0]  IDLE_TERM = IW'(IDLE_TC - 1);
  localparam logic [IW-1:0]  IDLE_PEN  = IW'((IDLE_TC >= 2) ? IDLE_TC - 2 : 0);
  localparam logic [SW-1:0]  STEP_TERM = SW'(STEP_CYCLES - 1);
  localparam logic [DLW-1:0] DIM_MAX   = DLW'(DIM_SHIFT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FADE, S_DIMMED} state_t;

  state_t         r_state;
  logic           r_btn_prev;
  logic           r_user_pause;
  logic           r_pause_cpu;
  logic [IW-1:0]  r_idle;
  logic [SW-1:0]  r_step;
  logic [DLW-1:0] r_dim_level;
  logic [CW-1:0]  r_rgb;

  logic           w_btn_rise;
  logic           w_dim_on;
  logic           w_idle_done;
  logic [RW-1:0]  w_r;
  logic [GW-1:0]  w_g;
  logic [BW-1:0]  w_b;

  assign w_btn_rise = user_button & ~r_btn_prev;
  assign w_dim_on   = r_pause_cpu & options[1];
  // The last idle increment lands on the same edge that enters the fade.
  assign w_idle_done = ((r_state == S_WAIT) && (r_idle == IDLE_PEN)) ||
                       ((r_state == S_RUN) && (IDLE_TC <= 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_btn_prev   <= 1'b0;
      r_user_pause <= 1'b0;
      r_pause_cpu  <= 1'b0;
    end else begin
      r_btn_prev <= user_button;
      if (w_btn_rise) r_user_pause <= ~r_user_pause;
      r_pause_cpu <= r_user_pause | (|pause_req) | (options[0] & osd_status);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_idle      <= '0;
      r_step      <= '0;
      r_dim_level <= '0;
    end else if (!w_dim_on) begin
      r_state     <= S_RUN;
      r_idle      <= '0;
      r_step      <= '0;
      r_dim_level <= '0;
    end else begin
      case (r_state)
        S_RUN, S_WAIT: begin
          if (w_idle_done) begin
            r_idle      <= IDLE_TERM;
            r_step      <= '0;
            r_dim_level <= DLW'(1);
            r_state     <= (DIM_SHIFT == 1) ? S_DIMMED : S_FADE;
          end else if (r_state == S_RUN) begin
            r_state <= S_WAIT;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_FADE: begin
          if (r_step == STEP_TERM) begin
            r_step      <= '0;
            r_dim_level <= r_dim_level + 1'b1;
            if (r_dim_level + 1'b1 == DIM_MAX) r_state <= S_DIMMED;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: r_dim_level <= DIM_MAX;
      endcase
    end
  end

  assign w_r = rgb_in[CW-1 -: RW];
  assign w_g = rgb_in[BW +: GW];
  assign w_b = rgb_in[BW-1:0];

  // Per-field shifts keep each channel zero-filled with no bleed between fields.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_rgb <= '0;
    else       r_rgb <= {w_r >> r_dim_level, w_g >> r_dim_level, w_b >> r_dim_level};
  end

  assign pause_cpu = r_pause_cpu;
  assign rgb_out   = r_rgb;
  assign dim_level = r_dim_level;

endmodule

// File: tb/tb_pause_fade_ctl.sv
// Scoreboard bench for pause_fade_ctl: a cycle model pushes expected outputs,
// a monitor pops and compares them; directed phases followed by random traffic.
module tb_pause_fade_ctl;
  localparam int NREQ = 2;
  localparam int TC   = 10 * 2;
  localparam int STEP = 3;
  localparam int DS   = 2;

  logic            clk_sys     = 1'b0;
  logic            reset       = 1'b1;
  logic            user_button = 1'b0;
  logic [NREQ-1:0] pause_req   = '0;
  logic            osd_status  = 1'b0;
  logic [1:0]      options     = 2'b00;
  logic [7:0]      rgb_in      = 8'h00;
  logic            pause_cpu;
  logic [7:0]      rgb_out;
  logic [1:0]      dim_level;

  int errors = 0;
  int checks = 0;
  bit rnd_rgb = 0;
  logic [10:0] exp_q[$];

  pause_fade_ctl #(
    .RW(3), .GW(3), .BW(2), .NREQ(NREQ), .CLK_HZ(10), .DIM_SEC(2),
    .DIM_SHIFT(DS), .STEP_CYCLES(STEP)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
    .pause_req(pause_req), .osd_status(osd_status), .options(options),
    .rgb_in(rgb_in), .pause_cpu(pause_cpu), .rgb_out(rgb_out),
    .dim_level(dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  // Dim depth depends only on how many consecutive edges saw pause with dim enabled.
  function automatic int exp_dim(input int n);
    int d;
    if (n < TC) return 0;
    d = 1 + (n - TC) / STEP;
    return (d > DS) ? DS : d;
  endfunction

  function automatic logic [7:0] dimf(input logic [7:0] v, input int s);
    logic [2:0] r, g;
    logic [1:0] b;
    r = v[7:5] >> s;
    g = v[4:2] >> s;
    b = v[1:0] >> s;
    return {r, g, b};
  endfunction

  bit         m_up, m_prev, m_pc;
  int         m_n, m_dim;
  logic [7:0] m_rgb;

  always @(posedge clk_sys) begin : model
    logic [7:0] nrgb;
    logic       npc;
    if (reset) begin
      m_up = 0; m_prev = 0; m_pc = 0; m_n = 0; m_dim = 0; m_rgb = 8'h00;
    end else begin
      nrgb = dimf(rgb_in, m_dim);
      if (m_pc && options[1]) m_n = (m_n < 1000000) ? m_n + 1 : m_n;
      else                    m_n = 0;
      npc  = m_up | (|pause_req) | (options[0] & osd_status);
      m_up = m_up ^ (user_button & ~m_prev);
      m_prev = user_button;
      m_pc  = npc;
      m_dim = exp_dim(m_n);
      m_rgb = nrgb;
    end
    exp_q.push_back({m_pc, m_rgb, 2'(m_dim)});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wakes on each falling clock edge and on async reset assertion mid-cycle.
  always @(negedge clk_sys or posedge reset) begin : monitor
    logic [10:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pause_cpu", 32'(pause_cpu), 32'(e[10]));
      chk("rgb_out",   32'(rgb_out),   32'(e[9:2]));
      chk("dim_level", 32'(dim_level), 32'(e[1:0]));
    end else if (reset) begin
      chk("async_pause_cpu", 32'(pause_cpu), 32'd0);
      chk("async_rgb_out",   32'(rgb_out),   32'd0);
      chk("async_dim_level", 32'(dim_level), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      if (rnd_rgb) rgb_in = 8'($urandom);
    end
  endtask

  task automatic press();
    user_button = 1'b1;
    step(1);
    user_button = 1'b0;
  endtask

  initial begin
    rgb_in = 8'hFF;
    step(3);
    reset = 1'b0;
    step(3);

    rnd_rgb = 1;
    user_button = 1'b1; step(5); user_button = 1'b0; step(3);
    press(); step(3);

    options = 2'b10; rnd_rgb = 0; rgb_in = 8'b111_110_11;
    press(); step(35);
    press(); step(4);

    rnd_rgb = 1;
    pause_req = 2'b10; step(15); pause_req = 2'b00; step(4);

    osd_status = 1'b1; step(4);
    options = 2'b11; step(4);
    osd_status = 1'b0; options = 2'b10; step(3);

    press(); step(25);
    options = 2'b00; step(3);
    options = 2'b10; step(5);
    press(); step(3);

    press(); pause_req = 2'b01; step(10);
    press(); step(30);
    pause_req = 2'b00; step(3);

    press(); step(24);
    #2 reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);

    for (int i = 0; i < 3000; i++) begin
      user_button = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) pause_req[0] = ~pause_req[0];
      if ($urandom_range(0, 59) == 0) pause_req[1] = ~pause_req[1];
      if ($urandom_range(0, 59) == 0) osd_status = ~osd_status;
      if ($urandom_range(0, 89) == 0) options = 2'($urandom);
      step(1);
    end
    user_button = 1'b0;
    step(2);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
